// File: rtl/fft_pkg.sv
// Shared types and constants for the fft frame sequencer.
package fft_pkg;

    localparam int FRAME_CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        COMPUTE = 3'd2,
        START   = 3'd3,
        DRAIN   = 3'd4
    } seq_state_t;

    // Address width for an N-point frame; never narrower than one bit.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sample_decimator.sv
// Passes one of every DECIM valid ADC samples; the count restarts whenever clear is high.
module sample_decimator #(
    parameter int DECIM = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic sample_valid,
    output logic accept
);

    localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [CW-1:0] LAST = CW'(DECIM - 1);

    logic [CW-1:0] cnt;

    assign accept = !clear && sample_valid && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (sample_valid) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fft_frame_sequencer.sv
// Loads decimated ADC frames into the fft core, waits for the spectrum and hands it to the SPI dump.
//
// state   | meaning
// IDLE    | stopped, waiting for enable
// LOAD    | writing accepted samples to addr 0..N-1
// COMPUTE | waiting for fft_finish, bounded by TIMEOUT
// START   | waiting for the SPI link to be free, then pulse start_spi
// DRAIN   | waiting for the SPI dump to finish
module fft_frame_sequencer
    import fft_pkg::*;
#(
    parameter int N       = 32,
    parameter int MSB     = 16,
    parameter int DECIM   = 1,
    parameter int TIMEOUT = 4096
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   sample_valid,
    input  logic [MSB-1:0]         sample_in,
    input  logic                   fft_finish,
    input  logic                   spi_busy,
    output logic                   insert_data,
    output logic [MSB-1:0]         data_out,
    output logic [$clog2(N)-1:0]   addr,
    output logic                   start_spi,
    output logic                   busy,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic                   timeout_err
);

    localparam int AW = addr_w(N);
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    seq_state_t state, state_nxt;
    logic [AW-1:0]          idx, idx_nxt;
    logic [TW-1:0]          tmr, tmr_nxt;
    logic                   risen, risen_nxt;
    logic                   ins_nxt, start_nxt, terr_nxt;
    logic [MSB-1:0]         data_nxt;
    logic [AW-1:0]          addr_nxt;
    logic [FRAME_CNT_W-1:0] fc_nxt;
    logic                   accept;

    sample_decimator #(.DECIM(DECIM)) u_decim (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (!(state == LOAD && enable)),
        .sample_valid (sample_valid),
        .accept       (accept)
    );

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        tmr_nxt   = tmr;
        risen_nxt = risen;
        ins_nxt   = 1'b0;
        data_nxt  = data_out;
        addr_nxt  = addr;
        start_nxt = 1'b0;
        fc_nxt    = frame_count;
        terr_nxt  = timeout_err;
        case (state)
            IDLE: begin
                idx_nxt = '0;
                if (enable) state_nxt = LOAD;
            end
            LOAD: begin
                if (!enable) begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                end else if (accept) begin
                    ins_nxt  = 1'b1;
                    data_nxt = sample_in;
                    addr_nxt = idx;
                    idx_nxt  = idx + 1'b1;
                    if (idx == AW'(N - 1)) begin
                        state_nxt = COMPUTE;
                        tmr_nxt   = TW'(TIMEOUT - 1);
                    end
                end
            end
            COMPUTE: begin
                // A finish pulse coinciding with the last write belongs to no frame.
                if (fft_finish && !insert_data) begin
                    state_nxt = START;
                end else if (tmr == '0) begin
                    terr_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    tmr_nxt = tmr - 1'b1;
                end
            end
            START: begin
                if (!spi_busy) begin
                    start_nxt = 1'b1;
                    state_nxt = DRAIN;
                    tmr_nxt   = TW'(1);
                    risen_nxt = 1'b0;
                end
            end
            DRAIN: begin
                // Two-cycle window for spi_busy to rise; a dump that never starts still counts.
                if (spi_busy) begin
                    risen_nxt = 1'b1;
                end else if (risen || tmr == '0) begin
                    fc_nxt    = frame_count + 1'b1;
                    state_nxt = enable ? LOAD : IDLE;
                end else begin
                    tmr_nxt = tmr - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            tmr         <= '0;
            risen       <= 1'b0;
            insert_data <= 1'b0;
            data_out    <= '0;
            addr        <= '0;
            start_spi   <= 1'b0;
            busy        <= 1'b0;
            frame_count <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            tmr         <= tmr_nxt;
            risen       <= risen_nxt;
            insert_data <= ins_nxt;
            data_out    <= data_nxt;
            addr        <= addr_nxt;
            start_spi   <= start_nxt;
            busy        <= (state_nxt != IDLE);
            frame_count <= fc_nxt;
            timeout_err <= terr_nxt;
        end
    end

endmodule
